// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM stage between EX/MEM and MEM/WB.
// Non-memory instructions pass straight through to writeback one cycle later.
// Loads and stores drive a req/ack data-memory port with byte strobes.
// Read data is extracted from its lane and sign/zero extended.
// An optional ack timeout (WAIT_MAX > 0) aborts a request that never completes.
// Build option: define MEM_MISALIGN_TRAP_EN to report misaligned accesses as
// err_code 01 without touching memory. When it is undefined, the offset is
// truncated to the access alignment and the access proceeds.
module mem_access_unit #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int WAIT_MAX   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  is_load_i,
  input  logic                  is_store_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_W-1:0]     store_data_i,
  output logic                  stall_req_o,
  output logic                  valid_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     data_o,
  output logic [1:0]            err_code_o,
  output logic                  mem_ce_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W/8-1:0]   mem_sel_o,
  output logic [DATA_W-1:0]     mem_data_o,
  input  logic [DATA_W-1:0]     mem_data_i,
  input  logic                  mem_ack_i
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Request fields held for the duration of the access
  size_t            req_size;
  logic             req_unsigned;
  logic             req_store;
  logic             req_wreg;
  logic [OFF_W-1:0] req_off;

  // Decode of the instruction currently presented by EX/MEM
  logic             is_mem;
  size_t            in_size;
  logic [ADDR_W-1:0] in_addr;
  logic [OFF_W-1:0] in_off;
  logic [OFF_W-1:0] align_mask;
  logic [OFF_W-1:0] in_off_al;
  logic [NB-1:0]    in_sel;
  logic [DATA_W-1:0] in_wdata;
  logic             trap;
  logic             timeout_hit;
  logic [DATA_W-1:0] ld_shifted;
  logic [DATA_W-1:0] ld_data;

  assign is_mem  = is_load_i | is_store_i;
  assign in_addr = ADDR_W'(data_i);
  assign in_off  = in_addr[OFF_W-1:0];

  // Resolve access size and alignment mask; a doubleword collapses to a word on a 32-bit datapath
  // NOTE: every signal written in always_comb gets a default first so no path can infer a latch.
  always_comb begin
    in_size = size_t'(funct3_i[1:0]);
    if (DATA_W == 32 && in_size == SZ_D) in_size = SZ_W;
    align_mask = '1;
    case (in_size)
      SZ_B: align_mask = '1;
      SZ_H: align_mask = ~OFF_W'(1);
      SZ_W: align_mask = ~OFF_W'(3);
      SZ_D: align_mask = '0;
    endcase
  end

  assign in_off_al = in_off & align_mask;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (in_off & ~align_mask) != '0;
  assign trap       = valid_i & is_mem & misaligned;
`else
  assign trap = 1'b0;
`endif

  // Byte strobes for the aligned offset
  always_comb begin
    in_sel = '1;
    case (in_size)
      SZ_B: in_sel = NB'(1)  << in_off_al;
      SZ_H: in_sel = NB'(3)  << in_off_al;
      SZ_W: in_sel = NB'(15) << in_off_al;
      SZ_D: in_sel = '1;
    endcase
  end

  // Replicate the low byte/half/word of rs2 into every lane
  always_comb begin
    in_wdata = store_data_i;
    for (int i = 0; i < NB; i++) begin
      case (in_size)
        SZ_B:    in_wdata[8*i +: 8] = store_data_i[7:0];
        SZ_H:    in_wdata[8*i +: 8] = store_data_i[8*(i%2) +: 8];
        SZ_W:    in_wdata[8*i +: 8] = store_data_i[8*(i%4) +: 8];
        default: in_wdata[8*i +: 8] = store_data_i[8*i +: 8];
      endcase
    end
  end

  // Move the addressed lane down to bit 0, then extend it to full width
  assign ld_shifted = mem_data_i >> {req_off, 3'b000};

  // Sign or zero extension of the selected lane
  always_comb begin
    ld_data = ld_shifted;
    case (req_size)
      SZ_B: if (req_unsigned) ld_data = DATA_W'(ld_shifted[7:0]);
            else              ld_data = DATA_W'($signed(ld_shifted[7:0]));
      SZ_H: if (req_unsigned) ld_data = DATA_W'(ld_shifted[15:0]);
            else              ld_data = DATA_W'($signed(ld_shifted[15:0]));
      SZ_W: if (req_unsigned) ld_data = DATA_W'(ld_shifted[31:0]);
            else              ld_data = DATA_W'($signed(ld_shifted[31:0]));
      SZ_D: ld_data = ld_shifted;
    endcase
  end

  // The abort fires in the WAIT_MAX-th BUSY cycle without ack; an ack in that cycle takes priority
  assign timeout_hit = (WAIT_MAX != 0) && (state == BUSY) && !mem_ack_i &&
                       (wait_cnt == CNT_W'(WAIT_MAX - 1));

  // Upstream holds while a request is being accepted or is outstanding. The completing
  // cycle (ack or abort) releases it so EX/MEM advances and the instruction is not reissued.
  assign stall_req_o = (state == IDLE) ? (valid_i & is_mem & ~trap)
                                       : ~(mem_ack_i | timeout_hit);

  // Stage FSM: accept, issue, wait for ack or timeout, then produce one result pulse
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      req_size     <= SZ_B;
      req_unsigned <= 1'b0;
      req_store    <= 1'b0;
      req_wreg     <= 1'b0;
      req_off      <= '0;
      valid_o      <= 1'b0;
      wd_o         <= '0;
      wreg_o       <= 1'b0;
      data_o       <= '0;
      err_code_o   <= ERR_NONE;
      mem_ce_o     <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_sel_o    <= '0;
      mem_data_o   <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            if (!is_mem) begin
              valid_o    <= 1'b1;
              wd_o       <= wd_i;
              wreg_o     <= wreg_i;
              data_o     <= data_i;
              err_code_o <= ERR_NONE;
            end else if (trap) begin
              valid_o    <= 1'b1;
              wd_o       <= wd_i;
              wreg_o     <= 1'b0;
              data_o     <= '0;
              err_code_o <= ERR_MISALIGN;
            end else begin
              state        <= BUSY;
              wait_cnt     <= '0;
              req_size     <= in_size;
              req_unsigned <= funct3_i[2];
              req_store    <= is_store_i;
              req_wreg     <= wreg_i;
              req_off      <= in_off_al;
              wd_o         <= wd_i;
              mem_ce_o     <= 1'b1;
              mem_we_o     <= is_store_i;
              mem_addr_o   <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_sel_o    <= in_sel;
              mem_data_o   <= in_wdata;
            end
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            state      <= IDLE;
            mem_ce_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            valid_o    <= 1'b1;
            err_code_o <= ERR_NONE;
            wreg_o     <= req_store ? 1'b0 : req_wreg;
            data_o     <= req_store ? '0 : ld_data;
          end else if (timeout_hit) begin
            state      <= IDLE;
            mem_ce_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            valid_o    <= 1'b1;
            err_code_o <= ERR_TIMEOUT;
            wreg_o     <= 1'b0;
            data_o     <= '0;
          end else if (WAIT_MAX != 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit -- randomized self-checking bench for mem_access_unit
// (32-bit datapath, WAIT_MAX = 4). Expected values come from an arithmetic
// reference model of the access rules, never from the DUT.
// Honours MEM_MISALIGN_TRAP_EN when it is defined for the build.
module tb_mem_access_unit;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 5;
  localparam int WM = 4;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_i;
  logic [RW-1:0] wd_i;
  logic          wreg_i;
  logic [DW-1:0] data_i;
  logic          is_load_i;
  logic          is_store_i;
  logic [2:0]    funct3_i;
  logic [DW-1:0] store_data_i;
  logic          stall_req_o;
  logic          valid_o;
  logic [RW-1:0] wd_o;
  logic          wreg_o;
  logic [DW-1:0] data_o;
  logic [1:0]    err_code_o;
  logic          mem_ce_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_sel_o;
  logic [DW-1:0] mem_data_o;
  logic [DW-1:0] mem_data_i;
  logic          mem_ack_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Observations of the most recent memory instruction, for literal test-plan checks
  logic [31:0] last_addr, last_wdata, last_data;
  logic [3:0]  last_sel;
  logic [1:0]  last_err;
  logic        last_we, last_wreg, last_ce;

  mem_access_unit #(
    .DATA_W(DW), .ADDR_W(AW), .REG_ADDR_W(RW), .WAIT_MAX(WM)
  ) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .data_i(data_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
    .funct3_i(funct3_i), .store_data_i(store_data_i), .stall_req_o(stall_req_o),
    .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o), .data_o(data_o),
    .err_code_o(err_code_o), .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    valid_i = 1'b0; wd_i = '0; wreg_i = 1'b0; data_i = '0;
    is_load_i = 1'b0; is_store_i = 1'b0; funct3_i = '0; store_data_i = '0;
  endtask

  // Garbage on the inputs while BUSY: the DUT must ignore all of it
  task automatic scramble();
    valid_i = 1'($urandom); wd_i = RW'($urandom); wreg_i = 1'($urandom);
    data_i = $urandom; is_load_i = 1'($urandom); is_store_i = 1'($urandom);
    funct3_i = 3'($urandom); store_data_i = $urandom;
  endtask

  // ---------------- reference model ----------------
  // Access width in bytes; a doubleword code is a word on this 32-bit datapath
  function automatic int unsigned size_of(input logic [2:0] f3);
    int unsigned s;
    s = 1 << f3[1:0];
    if (s > 4) s = 4;
    return s;
  endfunction

  function automatic logic [31:0] store_ref(input int unsigned sz, input logic [31:0] sd);
    longint unsigned mask, v;
    mask = (64'd1 << (8 * sz)) - 1;
    v = sd;
    v = v & mask;
    if (sz == 1)      v = v * 64'h0101_0101;
    else if (sz == 2) v = v * 64'h0001_0001;
    return 32'(v);
  endfunction

  function automatic logic [31:0] load_ref(input logic [2:0] f3, input int unsigned aoff,
                                           input logic [31:0] rd);
    int unsigned sz;
    longint unsigned mask, v;
    sz   = size_of(f3);
    mask = (64'd1 << (8 * sz)) - 1;
    v    = rd;
    v    = (v >> (8 * aoff)) & mask;
    if (!f3[2] && ((v >> (8 * sz - 1)) & 64'd1) == 64'd1) v = v | ~mask;
    return 32'(v);
  endfunction

  // ---------------- transactions ----------------
  task automatic do_alu(input logic [RW-1:0] wd, input logic wr, input logic [31:0] d);
    valid_i = 1'b1; wd_i = wd; wreg_i = wr; data_i = d;
    is_load_i = 1'b0; is_store_i = 1'b0; funct3_i = 3'($urandom); store_data_i = $urandom;
    #1 check("alu_stall", stall_req_o, 1'b0);
    cycle();
    check("alu_valid", valid_o, 1'b1);
    check("alu_wd", wd_o, wd);
    check("alu_wreg", wreg_o, wr);
    check("alu_data", data_o, d);
    check("alu_err", err_code_o, 2'b00);
    check("alu_ce", mem_ce_o, 1'b0);
  endtask

  task automatic do_mem(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rd, input int lat,
                        input logic [RW-1:0] wd, input logic wr);
    int unsigned sz, off, aoff;
    bit          trap;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [3:0]  e_sel;
    sz      = size_of(f3);
    off     = addr % 4;
    aoff    = off - (off % sz);
    trap    = TRAP && ((off % sz) != 0);
    e_addr  = addr - off;
    e_sel   = 4'(((1 << sz) - 1) << aoff);
    e_wdata = store_ref(sz, sd);
    e_data  = st ? 32'h0 : load_ref(f3, aoff, rd);

    valid_i = 1'b1; wd_i = wd; wreg_i = wr; data_i = addr;
    is_load_i = ld; is_store_i = st; funct3_i = f3; store_data_i = sd;
    #1 check("accept_stall", stall_req_o, !trap);
    cycle();
    if (trap) begin
      check("trap_valid", valid_o, 1'b1);
      check("trap_err", err_code_o, 2'b01);
      check("trap_wreg", wreg_o, 1'b0);
      check("trap_data", data_o, 32'h0);
      check("trap_ce", mem_ce_o, 1'b0);
      last_err = err_code_o; last_ce = mem_ce_o;
      drive_idle();
      cycle();
      check("trap_pulse", valid_o, 1'b0);
      check("trap_idle_ce", mem_ce_o, 1'b0);
      return;
    end
    check("req_ce", mem_ce_o, 1'b1);
    check("req_we", mem_we_o, st);
    check("req_addr", mem_addr_o, e_addr);
    check("req_sel", mem_sel_o, e_sel);
    if (st) check("req_wdata", mem_data_o, e_wdata);
    check("req_valid", valid_o, 1'b0);
    last_addr = mem_addr_o; last_sel = mem_sel_o; last_we = mem_we_o; last_wdata = mem_data_o;
    for (int k = 0; k < lat; k++) begin
      scramble();
      #1 check("busy_stall", stall_req_o, 1'b1);
      cycle();
      check("busy_ce", mem_ce_o, 1'b1);
      check("busy_addr", mem_addr_o, e_addr);
      check("busy_valid", valid_o, 1'b0);
    end
    scramble();
    mem_ack_i = 1'b1; mem_data_i = rd;
    #1 check("ack_stall", stall_req_o, 1'b0);
    cycle();
    mem_ack_i = 1'b0; mem_data_i = $urandom;
    check("res_valid", valid_o, 1'b1);
    check("res_ce", mem_ce_o, 1'b0);
    check("res_err", err_code_o, 2'b00);
    check("res_wd", wd_o, wd);
    check("res_wreg", wreg_o, st ? 1'b0 : wr);
    check("res_data", data_o, e_data);
    last_data = data_o; last_err = err_code_o; last_wreg = wreg_o; last_ce = mem_ce_o;
    drive_idle();
    cycle();
    check("res_pulse", valid_o, 1'b0);
  endtask

  initial begin
    logic [2:0] ld_codes [7];
    ld_codes[0] = 3'b000; ld_codes[1] = 3'b001; ld_codes[2] = 3'b010; ld_codes[3] = 3'b100;
    ld_codes[4] = 3'b101; ld_codes[5] = 3'b011; ld_codes[6] = 3'b110;

    // Reset state
    rst = 1'b1; mem_ack_i = 1'b0; mem_data_i = '0;
    drive_idle();
    cycle(); cycle();
    check("rst_valid", valid_o, 1'b0);
    check("rst_ce", mem_ce_o, 1'b0);
    check("rst_we", mem_we_o, 1'b0);
    check("rst_data", data_o, 32'h0);
    check("rst_err", err_code_o, 2'b00);
    check("rst_sel", mem_sel_o, 4'h0);
    rst = 1'b0;
    #1 check("rst_stall", stall_req_o, 1'b0);

    // ALU pass-through
    cycle();
    do_alu(5'd5, 1'b1, 32'h1234);
    drive_idle();
    cycle();
    check("alu_pulse", valid_o, 1'b0);

    // LB at 0x103, ack after 3 BUSY cycles (also the ack-wins-at-limit boundary)
    do_mem(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 3, 5'd7, 1'b1);
    check("lb_sel_lit", last_sel, 4'b1000);
    check("lb_addr_lit", last_addr, 32'h100);
    check("lb_data_lit", last_data, 32'hFFFF_FF80);

    // SH at 0x202, immediate ack
    do_mem(1'b0, 1'b1, 3'b001, 32'h202, 32'hAAAA_BEEF, 32'h0, 0, 5'd9, 1'b1);
    check("sh_we_lit", last_we, 1'b1);
    check("sh_sel_lit", last_sel, 4'b1100);
    check("sh_wdata_lit", last_wdata, 32'hBEEF_BEEF);
    check("sh_wreg_lit", last_wreg, 1'b0);

    // LHU at 0x0, no ack: abort after WM BUSY cycles, later ack ignored
    valid_i = 1'b1; wd_i = 5'd3; wreg_i = 1'b1; data_i = 32'h0;
    is_load_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b101; store_data_i = '0;
    #1 check("to_accept_stall", stall_req_o, 1'b1);
    cycle();
    for (int k = 0; k < WM; k++) begin
      check("to_busy_ce", mem_ce_o, 1'b1);
      check("to_busy_valid", valid_o, 1'b0);
      scramble();
      if (k < WM - 1) #1 check("to_busy_stall", stall_req_o, 1'b1);
      cycle();
    end
    check("to_valid", valid_o, 1'b1);
    check("to_err", err_code_o, 2'b10);
    check("to_wreg", wreg_o, 1'b0);
    check("to_ce", mem_ce_o, 1'b0);
    drive_idle();
    mem_ack_i = 1'b1; mem_data_i = 32'h1111_1111;
    #1 check("late_ack_stall", stall_req_o, 1'b0);
    cycle();
    mem_ack_i = 1'b0;
    check("late_ack_valid", valid_o, 1'b0);
    check("late_ack_ce", mem_ce_o, 1'b0);

    // LW at 0x102: trap or truncate depending on the build
    do_mem(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'hCAFE_BABE, 1, 5'd11, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
    check("lw_mis_err_lit", last_err, 2'b01);
    check("lw_mis_ce_lit", last_ce, 1'b0);
`else
    check("lw_mis_addr_lit", last_addr, 32'h100);
    check("lw_mis_sel_lit", last_sel, 4'b1111);
    check("lw_mis_data_lit", last_data, 32'hCAFE_BABE);
`endif

    // Randomized mix of ALU, load and store traffic
    for (int n = 0; n < 60; n++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      a    = $urandom & 32'h0000_FFFF;
      if (kind == 0) begin
        do_alu(RW'($urandom), 1'($urandom), $urandom);
      end else if (kind == 1) begin
        do_mem(1'b1, 1'b0, ld_codes[$urandom_range(0, 6)], a, $urandom, $urandom,
               $urandom_range(0, WM - 1), RW'($urandom), 1'($urandom));
      end else begin
        do_mem(1'($urandom), 1'b1, 3'($urandom_range(0, 2)), a, $urandom, $urandom,
               $urandom_range(0, WM - 1), RW'($urandom), 1'($urandom));
      end
    end
    drive_idle();
    cycle();

    // Reset in the second BUSY cycle
    valid_i = 1'b1; wd_i = 5'd12; wreg_i = 1'b1; data_i = 32'h300;
    is_load_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010; store_data_i = '0;
    cycle();
    drive_idle();
    check("rb_busy1_ce", mem_ce_o, 1'b1);
    cycle();
    check("rb_busy2_ce", mem_ce_o, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rb_valid", valid_o, 1'b0);
    check("rb_ce", mem_ce_o, 1'b0);
    check("rb_we", mem_we_o, 1'b0);
    check("rb_addr", mem_addr_o, 32'h0);
    check("rb_sel", mem_sel_o, 4'h0);
    check("rb_wd", wd_o, 5'd0);
    check("rb_data", data_o, 32'h0);
    check("rb_err", err_code_o, 2'b00);
    mem_ack_i = 1'b1; mem_data_i = 32'h2222_2222;
    #1 check("rb_stall", stall_req_o, 1'b0);
    cycle();
    mem_ack_i = 1'b0;
    check("rb_ack_valid", valid_o, 1'b0);
    check("rb_ack_ce", mem_ce_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
